// File: rtl/haar_band_arbiter.sv
// haar_band_arbiter
//
// Serializes the STAGES+1 band outputs of a Haar analysis filter bank onto a
// single valid/ready stream. Each band has a one-entry holding buffer. A
// sample that arrives while its band's buffer is still occupied, and is not
// being drained that cycle, is discarded and flagged in a sticky overflow bit.
//
// Parameters:
//   STAGES     - decomposition stages; the block serves STAGES+1 bands
//   OUT_WIDTH  - per-band sample width
//   BAND_WIDTH - width of the band tag; 2**BAND_WIDTH must be >= STAGES+1
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - asynchronous reset, active low
//   inStrobes     - per-band sample-valid pulses
//   dataIn        - band b sample at [OUT_WIDTH*b +: OUT_WIDTH]
//   outValid      - serialized sample valid
//   outReady      - downstream accepts the sample
//   outData       - serialized sample, unmodified
//   outBand       - band index of outData
//   overflow      - sticky per-band drop flags
//   clearOverflow - synchronous clear of all overflow flags
//
// Build option:
//   HAAR_ARB_FIXED_PRIORITY_EN - when defined, the highest full band wins and
//   no round-robin pointer exists. When undefined (default), arbitration is
//   round-robin starting at a pointer that moves past each granted band.

module haar_band_arbiter #(
    parameter int STAGES     = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int BAND_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [STAGES:0]                 inStrobes,
    input  logic [OUT_WIDTH*(STAGES+1)-1:0] dataIn,
    output logic                            outValid,
    input  logic                            outReady,
    output logic [OUT_WIDTH-1:0]            outData,
    output logic [BAND_WIDTH-1:0]           outBand,
    output logic [STAGES:0]                 overflow,
    input  logic                            clearOverflow
);

    localparam int NB = STAGES + 1;

    logic [OUT_WIDTH-1:0]  buf_data [NB];
    logic [NB-1:0]         full;
    logic                  loadable;
    logic                  grant_any;
    logic [BAND_WIDTH-1:0] grant_band;
    logic [OUT_WIDTH-1:0]  grant_data;
    logic [NB-1:0]         grant_hot;
    logic [NB-1:0]         capture;
    logic [NB-1:0]         drop;

    // The output register can take a new sample when it is empty or its
    // current sample is being consumed this cycle.
    assign loadable = !outValid || outReady;

`ifdef HAAR_ARB_FIXED_PRIORITY_EN

    // Ascending scan with overwrite leaves the highest full band as winner.
    always_comb begin
        grant_any  = 1'b0;
        grant_band = '0;
        grant_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (loadable && full[b]) begin
                grant_any  = 1'b1;
                grant_band = BAND_WIDTH'(b);
                grant_data = buf_data[b];
            end
        end
    end

`else

    logic [BAND_WIDTH-1:0] ptr;
    int                    rr_best;
    int                    rr_dist;

    // Each full band's distance from the pointer (modulo band count) is its
    // rank; the smallest distance wins, which is a circular search from ptr.
    always_comb begin
        grant_any  = 1'b0;
        grant_band = '0;
        grant_data = '0;
        rr_best    = NB;
        rr_dist    = 0;
        for (int b = 0; b < NB; b++) begin
            if (loadable && full[b]) begin
                rr_dist = (b + NB - int'(ptr)) % NB;
                if (rr_dist < rr_best) begin
                    rr_best    = rr_dist;
                    grant_any  = 1'b1;
                    grant_band = BAND_WIDTH'(b);
                    grant_data = buf_data[b];
                end
            end
        end
    end

    // The pointer moves one past the band just granted, wrapping at NB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_band == BAND_WIDTH'(NB - 1)) ? '0 : grant_band + 1'b1;
        end
    end

`endif

    // A strobe is accepted if its buffer is empty or is being drained in the
    // same cycle; otherwise the new sample is the one that gets dropped.
    always_comb begin
        grant_hot = '0;
        capture   = '0;
        drop      = '0;
        for (int b = 0; b < NB; b++) begin
            grant_hot[b] = grant_any && (grant_band == BAND_WIDTH'(b));
            capture[b]   = inStrobes[b] && (!full[b] || grant_hot[b]);
            drop[b]      = inStrobes[b] && full[b] && !grant_hot[b];
        end
    end

    // Per-band holding buffers. A refill on the granting cycle keeps the
    // full flag set so back-to-back samples on one band stream without gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= '0;
            for (int b = 0; b < NB; b++) begin
                buf_data[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (capture[b]) begin
                    buf_data[b] <= dataIn[OUT_WIDTH*b +: OUT_WIDTH];
                end
                full[b] <= capture[b] || (full[b] && !grant_hot[b]);
            end
        end
    end

    // Sticky drop flags; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= '0;
        end else begin
            overflow <= drop | (overflow & ~{NB{clearOverflow}});
        end
    end

    // Output register: loads on grant, empties when consumed with nothing
    // new to load, and otherwise holds data and band stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outValid <= 1'b0;
            outData  <= '0;
            outBand  <= '0;
        end else if (grant_any) begin
            outValid <= 1'b1;
            outData  <= grant_data;
            outBand  <= grant_band;
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule
